// File: rtl/dec_pkg.sv
// Shared definitions for the serial 1-to-N decoder MAC layer: state enum, fixed-point defaults
// and a lane-slice helper for packed lane vectors.
package dec_pkg;

  localparam int unsigned FracBitsDef = 8;

  // Widest lane and packed vector the slice helper can handle.
  localparam int unsigned MaxLaneW = 64;
  localparam int unsigned MaxVecW  = 1024;

  typedef enum logic {
    StIdle,
    StRun
  } dec_state_e;

  // Lane k of a packed vector whose lanes are width bits wide, zero-extended to MaxLaneW.
  function automatic logic [MaxLaneW-1:0] lane_slice(input logic [MaxVecW-1:0] vec,
                                                     input int unsigned       width,
                                                     input int unsigned       k);
    logic [MaxVecW-1:0]  shifted;
    logic [MaxLaneW-1:0] mask;
    shifted = vec >> (width * k);
    mask    = ~({MaxLaneW{1'b1}} << width);
    return MaxLaneW'(shifted) & mask;
  endfunction

endpackage

// File: rtl/fixed_point_add.sv
// Two's-complement fixed-point add, wrapping at BITSIZE.
module fixed_point_add #(
  parameter int unsigned BITSIZE = 16
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] c
);

  always_comb begin
    c = a + b;
  end

endmodule

// File: rtl/fixed_point_multiply.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC_BITS, wrapped to BITSIZE.
module fixed_point_multiply #(
  parameter int unsigned BITSIZE   = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] c
);

  logic signed [2*BITSIZE-1:0] product;

  always_comb begin
    product = $signed(a) * $signed(b);
    c       = BITSIZE'(product >>> FRAC_BITS);
  end

endmodule

// File: rtl/dec_1x6.sv
// Serial decoder MAC: y[k] = z*w[k] + b[k], one shared multiplier and adder pipelined over lanes.
// Multiply of lane m and add of lane m-1 overlap, so a run takes N_OUT+1 edges after acceptance.
module dec_1x6
  import dec_pkg::*;
#(
  parameter int unsigned BITSIZE   = 16,
  parameter int unsigned N_OUT     = 6,
  parameter int unsigned FRAC_BITS = FracBitsDef
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BITSIZE-1:0]       z,
  input  logic [BITSIZE*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0] b,
  output logic                     busy,
  output logic                     valid,
  output logic [BITSIZE*N_OUT-1:0] y
);

  localparam int unsigned CntW = $clog2(N_OUT + 1);

  dec_state_e               state_q;
  logic [BITSIZE-1:0]       z_q;
  logic [BITSIZE*N_OUT-1:0] w_q;
  logic [BITSIZE*N_OUT-1:0] b_q;
  logic [CntW-1:0]          m_q;
  logic [CntW-1:0]          a_q;
  logic [BITSIZE-1:0]       prod_q;

  logic [BITSIZE-1:0] w_lane;
  logic [BITSIZE-1:0] b_lane;
  logic [BITSIZE-1:0] mul_res;
  logic [BITSIZE-1:0] add_res;
  logic               mul_en;
  logic               add_en;

  always_comb begin
    w_lane = BITSIZE'(lane_slice(MaxVecW'(w_q), BITSIZE, 32'(m_q)));
    b_lane = BITSIZE'(lane_slice(MaxVecW'(b_q), BITSIZE, 32'(a_q)));
    mul_en = (m_q < CntW'(N_OUT));
    // The add stage trails the multiplier by one edge, so it starts once a product exists.
    add_en = (m_q != '0);
  end

  fixed_point_multiply #(
    .BITSIZE  (BITSIZE),
    .FRAC_BITS(FRAC_BITS)
  ) u_mul (
    .a(z_q),
    .b(w_lane),
    .c(mul_res)
  );

  fixed_point_add #(
    .BITSIZE(BITSIZE)
  ) u_add (
    .a(prod_q),
    .b(b_lane),
    .c(add_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      z_q     <= '0;
      w_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      prod_q  <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      y       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            z_q     <= z;
            w_q     <= w;
            b_q     <= b;
            m_q     <= '0;
            a_q     <= '0;
            busy    <= 1'b1;
            valid   <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (mul_en) begin
            prod_q <= mul_res;
            m_q    <= m_q + 1'b1;
          end
          if (add_en) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
              if (a_q == CntW'(k)) y[BITSIZE*k +: BITSIZE] <= add_res;
            end
            a_q <= a_q + 1'b1;
            if (a_q == CntW'(N_OUT - 1)) begin
              busy    <= 1'b0;
              valid   <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_1x6.sv
// Self-checking bench for dec_1x6: directed and random runs against a lane-level arithmetic model.
module tb_dec_1x6;

  localparam int unsigned B = 16;
  localparam int unsigned N = 6;
  localparam int unsigned W = B * N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [B-1:0] z = '0;
  logic [W-1:0] w = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         valid;
  logic [W-1:0] y;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [W-1:0] exp_y = '0;

  always #5 clk = ~clk;

  dec_1x6 dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .z    (z),
    .w    (w),
    .b    (b),
    .busy (busy),
    .valid(valid),
    .y    (y)
  );

  // Reference: real-valued fixed-point product, floor-shifted, then wrapped 16-bit sum.
  function automatic logic [B-1:0] lane_val(input logic [B-1:0] lz, input logic [B-1:0] lw,
                                            input logic [B-1:0] lb);
    longint p;
    p = longint'($signed(lz)) * longint'($signed(lw));
    p = p >>> 8;
    return B'(p) + lb;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[B*k +: B] = B'($urandom);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted run. After E0 the inputs switch to nz/nw/nb; keep holds start high throughout,
  // pulse3 raises start for the E3 edge only (must be ignored).
  task automatic run(input logic [B-1:0] rz, input logic [W-1:0] rw, input logic [W-1:0] rb,
                     input logic [B-1:0] nz, input logic [W-1:0] nw, input logic [W-1:0] nb,
                     input bit keep, input bit pulse3);
    logic [W-1:0] old_y;
    logic [W-1:0] new_y;
    logic [W-1:0] expv;
    old_y = exp_y;
    for (int k = 0; k < N; k++) new_y[B*k +: B] = lane_val(rz, rw[B*k +: B], rb[B*k +: B]);
    z = rz;
    w = rw;
    b = rb;
    start = 1'b1;
    tick();
    chk("e0_busy", W'(busy), W'(1));
    chk("e0_valid", W'(valid), W'(0));
    start = keep;
    z = nz;
    w = nw;
    b = nb;
    for (int e = 1; e <= 7; e++) begin
      if (pulse3 && e == 3) start = 1'b1;
      tick();
      if (pulse3 && e == 3) start = 1'b0;
      expv = old_y;
      for (int k = 0; k < N; k++) if (k <= e - 2) expv[B*k +: B] = new_y[B*k +: B];
      chk("lanes", y, expv);
      chk("busy", W'(busy), W'(e < 7));
      chk("valid", W'(valid), W'(e == 7));
    end
    exp_y = new_y;
  endtask

  initial begin
    logic [W-1:0] uw;
    logic [W-1:0] ub;
    logic [W-1:0] dw;
    logic [W-1:0] db;
    logic [W-1:0] vw;
    logic [W-1:0] vb;
    logic [W-1:0] two80;
    for (int k = 0; k < N; k++) begin
      uw[B*k +: B] = 16'h0200;
      ub[B*k +: B] = 16'h0080;
      dw[B*k +: B] = B'(k * 16'h0100);
      db[B*k +: B] = 16'hFF00;
      two80[B*k +: B] = 16'h0280;
    end

    #12;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_valid", W'(valid), W'(0));
    chk("rst_y", y, '0);
    reset = 1'b0;
    tick();

    // Uniform lanes, checked against constants as well as the model.
    run(16'h0100, uw, ub, B'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b0);
    chk("uniform_const", y, two80);

    // Asynchronous reset between edges clears outputs without a clock edge.
    #3;
    reset = 1'b1;
    start = 1'b1;
    z = B'($urandom);
    w = rand_vec();
    b = rand_vec();
    #1;
    chk("async_busy", W'(busy), W'(0));
    chk("async_valid", W'(valid), W'(0));
    chk("async_y", y, '0);
    #1;
    start = 1'b0;
    reset = 1'b0;
    exp_y = '0;
    tick();

    // Distinct lanes, then a negative operand.
    run(16'h0180, dw, db, B'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b0);
    chk("distinct_l1", W'(y[B*1 +: B]), W'(16'h0080));
    chk("distinct_l5", W'(y[B*5 +: B]), W'(16'h0680));
    for (int k = 0; k < N; k++) begin
      vw[B*k +: B] = 16'h0300;
      vb[B*k +: B] = 16'h0000;
    end
    run(16'hFF00, vw, vb, B'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b0);
    chk("neg_l0", W'(y[B*0 +: B]), W'(16'hFD00));

    // Inputs change after E0 and a start pulse at E3 must be ignored.
    run(B'($urandom), rand_vec(), rand_vec(), B'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", W'(valid), W'(1));
      chk("idle_busy", W'(busy), W'(0));
      chk("idle_y", y, exp_y);
    end

    // Reset between E3 and E4, then a clean uniform run.
    z = 16'h0100;
    w = uw;
    b = ub;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("midrun_busy", W'(busy), W'(0));
    chk("midrun_valid", W'(valid), W'(0));
    chk("midrun_y", y, '0);
    #1;
    reset = 1'b0;
    exp_y = '0;
    tick();
    tick();
    chk("midrun_idle_busy", W'(busy), W'(0));
    chk("midrun_idle_y", y, '0);
    run(16'h0100, uw, ub, B'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b0);
    chk("after_reset_const", y, two80);

    // Back-to-back with start held: valid lasts one cycle, drops at the next acceptance.
    vw = rand_vec();
    vb = rand_vec();
    begin
      logic [B-1:0] vz;
      vz = B'($urandom);
      run(B'($urandom), rand_vec(), rand_vec(), vz, vw, vb, 1'b1, 1'b0);
      run(vz, vw, vb, B'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b0);
    end

    // Random runs with random idle gaps.
    for (int r = 0; r < 8; r++) begin
      run(B'($urandom), rand_vec(), rand_vec(), B'($urandom), rand_vec(), rand_vec(),
          1'b0, 1'b0);
      for (int i = 0; i < int'($urandom_range(3, 0)); i++) tick();
      chk("rand_hold_y", y, exp_y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
